// File: rtl/sp_types_pkg.sv
// Shared scratchpad types: the gemm read-FIFO entry layout and its mat_t encoding.
package sp_types_pkg;

    localparam int BITS_PER_ROW = 64;
    localparam int MAT_S_W      = 4;
    localparam int ROW_S_W      = 2;

    localparam logic [1:0] MAT_T_NONE    = 2'd0;
    localparam logic [1:0] MAT_T_INPUT   = 2'd1;
    localparam logic [1:0] MAT_T_WEIGHT  = 2'd2;
    localparam logic [1:0] MAT_T_PARTIAL = 2'd3;

    typedef struct packed {
        logic [1:0]              mat_t;
        logic [MAT_S_W-1:0]      mat_s;
        logic [ROW_S_W-1:0]      row_s;
        logic [BITS_PER_ROW-1:0] data;
    } gemmFIFO_t;

endpackage

// File: rtl/gemm_operand_collector_if.sv
// Bundle between the gemm read FIFO, the operand collector and the systolic array.
interface gemm_operand_collector_if #(
    parameter int BITS_PER_ROW = sp_types_pkg::BITS_PER_ROW
);
    import sp_types_pkg::*;

    logic                      gemmFIFO_empty;
    gemmFIFO_t                 gemmFIFO_rdata;
    logic                      gemmFIFO_REN;
    logic                      gemm_start;
    logic                      gemm_ready;
    logic [4*BITS_PER_ROW-1:0] gemm_input;
    logic [4*BITS_PER_ROW-1:0] gemm_weight;
    logic [4*BITS_PER_ROW-1:0] gemm_partial;
    logic [MAT_S_W-1:0]        gemm_mat_s;
    logic                      dup_err;
    logic                      type_err;

    modport master (
        input  gemmFIFO_empty, gemmFIFO_rdata, gemm_ready,
        output gemmFIFO_REN, gemm_start, gemm_input, gemm_weight, gemm_partial,
               gemm_mat_s, dup_err, type_err
    );

    modport slave (
        output gemmFIFO_empty, gemmFIFO_rdata, gemm_ready,
        input  gemmFIFO_REN, gemm_start, gemm_input, gemm_weight, gemm_partial,
               gemm_mat_s, dup_err, type_err
    );

endinterface

// File: rtl/gemm_operand_collector.sv
// Gathers 12 rows (input/weight/partial x 4) from the gemm FIFO in any order and
// presents them to the systolic array as one operand set with a start/ready handshake.
module gemm_operand_collector #(
    parameter int BITS_PER_ROW = sp_types_pkg::BITS_PER_ROW
) (
    input logic                      CLK,
    input logic                      RST,
    gemm_operand_collector_if.master bus
);
    import sp_types_pkg::*;

    localparam int NUM_ROWS = 12;

    typedef enum logic {COLLECT, ISSUE} state_t;

    state_t                  state, state_next;
    logic [BITS_PER_ROW-1:0] rows [NUM_ROWS];
    logic [NUM_ROWS-1:0]     valid, valid_set;
    logic [MAT_S_W-1:0]      mat_s_q;
    logic [3:0]              base, idx;
    logic                    legal, pop, start, handshake, dup_q, type_q;

    // Flat row index: input rows 0-3, weight rows 4-7, partial rows 8-11.
    always_comb begin
        legal = 1'b1;
        base  = 4'd0;
        case (bus.gemmFIFO_rdata.mat_t)
            MAT_T_INPUT:   base = 4'd0;
            MAT_T_WEIGHT:  base = 4'd4;
            MAT_T_PARTIAL: base = 4'd8;
            default:       legal = 1'b0;
        endcase
        idx = base + {2'b00, bus.gemmFIFO_rdata.row_s};
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        start      = 1'b0;
        handshake  = 1'b0;
        valid_set  = valid;
        case (state)
            COLLECT: begin
                pop = !bus.gemmFIFO_empty && !RST;
                if (pop && legal) valid_set[idx] = 1'b1;
                if (&valid_set) state_next = ISSUE;
            end
            ISSUE: begin
                start     = !RST;
                handshake = start && bus.gemm_ready;
                if (handshake) begin
                    state_next = COLLECT;
                    valid_set  = '0;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= COLLECT;
            valid   <= '0;
            mat_s_q <= '0;
            dup_q   <= 1'b0;
            type_q  <= 1'b0;
            for (int i = 0; i < NUM_ROWS; i++) rows[i] <= '0;
        end else begin
            state  <= state_next;
            valid  <= valid_set;
            dup_q  <= pop && legal && valid[idx];
            type_q <= pop && !legal;
            if (pop && legal) rows[idx] <= BITS_PER_ROW'(bus.gemmFIFO_rdata.data);
            if (pop && bus.gemmFIFO_rdata.mat_t == MAT_T_PARTIAL)
                mat_s_q <= bus.gemmFIFO_rdata.mat_s;
        end
    end

    assign bus.gemmFIFO_REN = pop;
    assign bus.gemm_start   = start;
    assign bus.gemm_input   = {rows[3], rows[2], rows[1], rows[0]};
    assign bus.gemm_weight  = {rows[7], rows[6], rows[5], rows[4]};
    assign bus.gemm_partial = {rows[11], rows[10], rows[9], rows[8]};
    assign bus.gemm_mat_s   = mat_s_q;
    assign bus.dup_err      = dup_q;
    assign bus.type_err     = type_q;

endmodule
